// File: rtl/edf_rd_scheduler.sv
// edf_rd_scheduler
//   Earliest-deadline-first read scheduler for a bank of NUM_Q FIFOs.
//   In IDLE it picks the non-empty queue whose head deadline is earliest,
//   using wrap-safe comparison against a free-running timebase. It pops
//   that queue for one cycle and captures the returned word. The word is
//   then held on a valid/ready output until downstream accepts it.
//
//   Optional feature: define EDF_SCHED_EXPIRED_DROP_EN to discard winners
//   whose deadline has already passed and count them in drop_count.
//
// Ports
//   fifo_rd_clk   sole clock, rising edge
//   rst_n         synchronous active-low reset
//   q_empty       per-queue empty flags
//   q_deadline    per-queue head deadline, TIME_W bits per queue
//   q_rd_en       one-hot FIFO read strobe
//   q_rd_data     per-queue read data, valid the cycle after q_rd_en
//   out_valid     served entry available
//   out_ready     downstream accepts the served entry
//   out_data      served entry data
//   out_qid       source queue of the served entry
//   out_deadline  deadline of the served entry
//   now           free-running timebase
//   drop_count    saturating count of expired entries discarded
module edf_rd_scheduler #(
  parameter int NUM_Q      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TIME_W     = 16,
  localparam int QID_W     = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
  input  logic                         fifo_rd_clk,
  input  logic                         rst_n,
  input  logic [NUM_Q-1:0]             q_empty,
  input  logic [NUM_Q*TIME_W-1:0]      q_deadline,
  output logic [NUM_Q-1:0]             q_rd_en,
  input  logic [NUM_Q*DATA_WIDTH-1:0]  q_rd_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [QID_W-1:0]             out_qid,
  output logic [TIME_W-1:0]            out_deadline,
  output logic [TIME_W-1:0]            now,
  output logic [15:0]                  drop_count
);

  typedef enum logic [2:0] {IDLE, READ, CAPT, HOLD, DROP} state_e;

  state_e                  state_q, state_d;
  logic [TIME_W-1:0]       now_q, now_d;
  logic [QID_W-1:0]        win_q, win_d;
  logic [TIME_W-1:0]       win_dl_q, win_dl_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [QID_W-1:0]        out_qid_q, out_qid_d;
  logic [TIME_W-1:0]       out_deadline_q, out_deadline_d;
`ifdef EDF_SCHED_EXPIRED_DROP_EN
  logic                    expired_q, expired_d;
  logic [15:0]             drop_count_q, drop_count_d;
`endif

  logic                    any_elig;
  logic [QID_W-1:0]        best_idx;
  logic [TIME_W-1:0]       best_dl;
  logic [DATA_WIDTH-1:0]   rd_slice;

  // Wrap-safe ordering: a is earlier than b when (a-b) is negative modulo 2^TIME_W.
  function automatic logic is_earlier(input logic [TIME_W-1:0] a,
                                      input logic [TIME_W-1:0] b);
    logic [TIME_W-1:0] diff;
    diff = a - b;
    return diff[TIME_W-1];
  endfunction

  // Ascending scan with a strict "earlier" test so ties stay with the lowest index.
  always_comb begin
    any_elig = 1'b0;
    best_idx = '0;
    best_dl  = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (!q_empty[i]) begin
        if (!any_elig || is_earlier(q_deadline[i*TIME_W +: TIME_W], best_dl)) begin
          any_elig = 1'b1;
          best_idx = QID_W'(i);
          best_dl  = q_deadline[i*TIME_W +: TIME_W];
        end
      end
    end
  end

  always_comb begin
    rd_slice = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (win_q == QID_W'(i)) rd_slice = q_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d        = state_q;
    now_d          = now_q + 1'b1;
    win_d          = win_q;
    win_dl_d       = win_dl_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_qid_d      = out_qid_q;
    out_deadline_d = out_deadline_q;
    q_rd_en        = '0;
`ifdef EDF_SCHED_EXPIRED_DROP_EN
    expired_d      = expired_q;
    drop_count_d   = drop_count_q;
`endif
    case (state_q)
      // Empty flags and deadlines are only trusted here, after any earlier pop has settled.
      IDLE: begin
        if (any_elig) begin
          win_d    = best_idx;
          win_dl_d = best_dl;
`ifdef EDF_SCHED_EXPIRED_DROP_EN
          expired_d = is_earlier(best_dl, now_q);
`endif
          state_d  = READ;
        end
      end
      READ: begin
        for (int i = 0; i < NUM_Q; i++) begin
          q_rd_en[i] = (win_q == QID_W'(i));
        end
        state_d = CAPT;
`ifdef EDF_SCHED_EXPIRED_DROP_EN
        if (expired_q) state_d = DROP;
`endif
      end
      CAPT: begin
        out_data_d     = rd_slice;
        out_qid_d      = win_q;
        out_deadline_d = win_dl_q;
        out_valid_d    = 1'b1;
        state_d        = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      DROP: begin
`ifdef EDF_SCHED_EXPIRED_DROP_EN
        if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fifo_rd_clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      now_q          <= '0;
      win_q          <= '0;
      win_dl_q       <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_qid_q      <= '0;
      out_deadline_q <= '0;
`ifdef EDF_SCHED_EXPIRED_DROP_EN
      expired_q      <= 1'b0;
      drop_count_q   <= '0;
`endif
    end else begin
      state_q        <= state_d;
      now_q          <= now_d;
      win_q          <= win_d;
      win_dl_q       <= win_dl_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_qid_q      <= out_qid_d;
      out_deadline_q <= out_deadline_d;
`ifdef EDF_SCHED_EXPIRED_DROP_EN
      expired_q      <= expired_d;
      drop_count_q   <= drop_count_d;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_qid      = out_qid_q;
  assign out_deadline = out_deadline_q;
  assign now          = now_q;
`ifdef EDF_SCHED_EXPIRED_DROP_EN
  assign drop_count   = drop_count_q;
`else
  assign drop_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_edf_rd_scheduler.sv
// Testbench for edf_rd_scheduler: behavioural FIFO bank, scoreboard of
// expected served entries, and a negedge monitor for protocol timing.
module tb_edf_rd_scheduler;

  localparam int NUM_Q = 4;
  localparam int DW    = 16;
  localparam int TW    = 16;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [1:0]  qid;
    logic [15:0] dl;
    logic [15:0] data;
  } expEntry;

  logic                 clock = 1'b0;
  logic                 rstN;
  logic [NUM_Q-1:0]     qEmpty;
  logic [NUM_Q*TW-1:0]  qDeadline;
  logic [NUM_Q-1:0]     qRdEn;
  logic [NUM_Q*DW-1:0]  qRdData;
  logic                 outValid;
  logic                 outReady;
  logic [DW-1:0]        outData;
  logic [1:0]           outQid;
  logic [TW-1:0]        outDeadline;
  logic [TW-1:0]        now;
  logic [15:0]          dropCount;

  // Behavioural FIFO bank state
  logic [TW-1:0]        fifoDl   [NUM_Q][DEPTH];
  logic [DW-1:0]        fifoData [NUM_Q][DEPTH];
  logic [2:0]           fifoHead [NUM_Q];
  logic [2:0]           fifoTail [NUM_Q];
  logic [3:0]           fifoCnt  [NUM_Q];
  logic                 fifoClear;
  logic [NUM_Q-1:0]     loadMask;
  logic [TW-1:0]        loadDl   [NUM_Q];
  logic [DW-1:0]        loadData [NUM_Q];
  logic [NUM_Q-1:0]     popV;

  expEntry sb[$];

  int checkCount = 0;
  int errorCount = 0;
  int cyc        = 0;
  int lastRdCyc  = -100;
  int rdTotal    = 0;
  int rdCnt [NUM_Q] = '{0, 0, 0, 0};
  int validRises = 0;
  logic          prevValid = 1'b0;
  logic          prevReady = 1'b0;
  logic [DW-1:0] prevData  = '0;
  logic [1:0]    prevQid   = '0;
  logic [TW-1:0] prevDl    = '0;

  edf_rd_scheduler #(.NUM_Q(NUM_Q), .DATA_WIDTH(DW), .TIME_W(TW)) dut (
    .fifo_rd_clk  (clock),
    .rst_n        (rstN),
    .q_empty      (qEmpty),
    .q_deadline   (qDeadline),
    .q_rd_en      (qRdEn),
    .q_rd_data    (qRdData),
    .out_valid    (outValid),
    .out_ready    (outReady),
    .out_data     (outData),
    .out_qid      (outQid),
    .out_deadline (outDeadline),
    .now          (now),
    .drop_count   (dropCount)
  );

  always #5 clock = ~clock;

  // Head-of-queue view presented to the scheduler
  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      qEmpty[i]              = (fifoCnt[i] == 4'd0);
      qDeadline[i*TW +: TW]  = fifoDl[i][fifoHead[i]];
      popV[i]                = qRdEn[i] && (fifoCnt[i] != 4'd0);
    end
  end

  // FIFO bank: pushes from the stimulus, pops on q_rd_en with data one cycle later
  always @(posedge clock) begin
    for (int i = 0; i < NUM_Q; i++) begin
      if (fifoClear) begin
        fifoHead[i] <= '0;
        fifoTail[i] <= '0;
        fifoCnt[i]  <= '0;
      end else begin
        if (loadMask[i]) begin
          fifoDl[i][fifoTail[i]]   <= loadDl[i];
          fifoData[i][fifoTail[i]] <= loadData[i];
          fifoTail[i]              <= fifoTail[i] + 3'd1;
        end
        if (popV[i]) begin
          qRdData[i*DW +: DW] <= fifoData[i][fifoHead[i]];
          fifoHead[i]         <= fifoHead[i] + 3'd1;
        end
        fifoCnt[i] <= fifoCnt[i] + 4'(loadMask[i]) - 4'(popV[i]);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] mkData(input int q, input logic [15:0] dl);
    return dl ^ (16'h1111 * 16'(q + 1)) ^ 16'hC3A5;
  endfunction

  task automatic expectServe(input int q, input logic [15:0] dl);
    expEntry e;
    e.qid  = 2'(q);
    e.dl   = dl;
    e.data = mkData(q, dl);
    sb.push_back(e);
  endtask

  // Push one entry into each queue selected by mask, all on the same edge
  task automatic applyStimulus(input logic [3:0] mask, input logic [15:0] d0,
                               input logic [15:0] d1, input logic [15:0] d2,
                               input logic [15:0] d3);
    loadDl[0] = d0; loadDl[1] = d1; loadDl[2] = d2; loadDl[3] = d3;
    for (int i = 0; i < NUM_Q; i++) loadData[i] = mkData(i, loadDl[i]);
    loadMask = mask;
    @(posedge clock);
    #1 loadMask = '0;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    repeat (2) @(posedge clock);
    #1 rstN = 1'b1;
  endtask

  task automatic waitDrain(input string tag, input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, 32'(sb.size()), 32'd0);
  endtask

  // Protocol monitor: strobe legality, valid latency, hold stability, scoreboard
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (rstN) begin
      if (qRdEn != '0) begin
        checkOutput("rd_onehot", 32'($onehot(qRdEn)), 32'd1);
        checkOutput("rd_nonempty", 32'(qRdEn & qEmpty), 32'd0);
        lastRdCyc <= cyc;
        rdTotal   <= rdTotal + 1;
        for (int i = 0; i < NUM_Q; i++) if (qRdEn[i]) rdCnt[i] <= rdCnt[i] + 1;
      end
      if (outValid && !prevValid) begin
        checkOutput("valid_latency", 32'(cyc - lastRdCyc), 32'd2);
        validRises <= validRises + 1;
      end
      if (outValid && prevValid && !prevReady) begin
        checkOutput("hold_data", 32'(outData), 32'(prevData));
        checkOutput("hold_qid", 32'(outQid), 32'(prevQid));
        checkOutput("hold_dl", 32'(outDeadline), 32'(prevDl));
      end
      if (outValid && outReady) begin
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected", 32'(sb.size()), 32'd1);
        end else begin
          checkOutput("sb_qid", 32'(outQid), 32'(sb[0].qid));
          checkOutput("sb_data", 32'(outData), 32'(sb[0].data));
          checkOutput("sb_dl", 32'(outDeadline), 32'(sb[0].dl));
          void'(sb.pop_front());
        end
      end
    end
    prevValid <= outValid;
    prevReady <= outReady;
    prevData  <= outData;
    prevQid   <= outQid;
    prevDl    <= outDeadline;
  end

  initial begin
    int n;
    int rdBefore;
    int riseBefore;
    rstN      = 1'b0;
    outReady  = 1'b1;
    loadMask  = '0;
    fifoClear = 1'b1;
    for (int i = 0; i < NUM_Q; i++) begin
      loadDl[i]   = '0;
      loadData[i] = '0;
    end

    // Reset values, then an idle stretch with every queue empty
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_now", 32'(now), 32'd0);
    checkOutput("rst_rd_en", 32'(qRdEn), 32'd0);
    checkOutput("rst_valid", 32'(outValid), 32'd0);
    checkOutput("rst_data", 32'(outData), 32'd0);
    checkOutput("rst_qid", 32'(outQid), 32'd0);
    checkOutput("rst_dl", 32'(outDeadline), 32'd0);
    checkOutput("rst_drop", 32'(dropCount), 32'd0);
    @(posedge clock);
    #1 rstN = 1'b1;
    fifoClear = 1'b0;
    repeat (20) @(posedge clock);
    @(negedge clock);
    checkOutput("idle_now", 32'(now), 32'd20);
    checkOutput("idle_rd_en", 32'(qRdEn), 32'd0);
    checkOutput("idle_valid", 32'(outValid), 32'd0);
    checkOutput("idle_rd_total", 32'(rdTotal), 32'd0);

    // EDF order with a deadline tie between q1 and q3
    @(posedge clock);
    #1 doReset();
    expectServe(1, 16'd40);
    expectServe(3, 16'd40);
    expectServe(2, 16'd70);
    expectServe(0, 16'd100);
    applyStimulus(4'b1111, 16'd100, 16'd40, 16'd70, 16'd40);
    waitDrain("edf_drain", 100);

    // Backpressure: hold for 10 cycles, then release and measure the reissue gap
    @(posedge clock);
    #1 doReset();
    outReady = 1'b0;
    expectServe(0, 16'd300);
    expectServe(2, 16'd400);
    applyStimulus(4'b0101, 16'd300, 16'd0, 16'd400, 16'd0);
    n = 0;
    while (!outValid && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("bp_valid", 32'(outValid), 32'd1);
    rdBefore = rdTotal;
    repeat (10) @(negedge clock);
    checkOutput("bp_no_rd", 32'(rdTotal - rdBefore), 32'd0);
    checkOutput("bp_still_valid", 32'(outValid), 32'd1);
    @(posedge clock);
    #1 outReady = 1'b1;
    @(negedge clock);
    n = 0;
    while (qRdEn == '0 && n < 10) begin
      @(negedge clock);
      n++;
    end
    checkOutput("bp_gap", 32'(n), 32'd2);
    checkOutput("bp_next_q", 32'(qRdEn), 32'b0100);
    waitDrain("bp_drain", 40);

    // Expired head: deadline 5 sampled at now=50
    @(posedge clock);
    #1 doReset();
    outReady = 1'b1;
    n = 0;
    while (now != 16'd49 && n < 100) begin
      @(posedge clock);
      #1 n++;
    end
    checkOutput("exp_now", 32'(now), 32'd49);
    rdBefore   = rdCnt[2];
    riseBefore = validRises;
`ifndef EDF_SCHED_EXPIRED_DROP_EN
    expectServe(2, 16'd5);
`endif
    applyStimulus(4'b0100, 16'd0, 16'd0, 16'd5, 16'd0);
    repeat (12) @(negedge clock);
    checkOutput("exp_rd_q2", 32'(rdCnt[2] - rdBefore), 32'd1);
`ifdef EDF_SCHED_EXPIRED_DROP_EN
    checkOutput("exp_drop", 32'(dropCount), 32'd1);
    checkOutput("exp_no_valid", 32'(validRises - riseBefore), 32'd0);
`else
    checkOutput("exp_drop", 32'(dropCount), 32'd0);
    checkOutput("exp_served", 32'(sb.size()), 32'd0);
`endif

    // Reset landing on the capture cycle discards the in-flight read
    applyStimulus(4'b0010, 16'd0, 16'd500, 16'd0, 16'd0);
    n = 0;
    while (qRdEn == '0 && n < 10) begin
      @(negedge clock);
      n++;
    end
    checkOutput("capt_rd", 32'(qRdEn), 32'b0010);
    riseBefore = validRises;
    @(posedge clock);
    #1 rstN = 1'b0;
    @(posedge clock);
    #1 rstN = 1'b1;
    repeat (5) @(negedge clock);
    checkOutput("capt_valid", 32'(outValid), 32'd0);
    checkOutput("capt_rises", 32'(validRises - riseBefore), 32'd0);
    checkOutput("capt_drop", 32'(dropCount), 32'd0);
    checkOutput("capt_rd_en", 32'(qRdEn), 32'd0);

    // Deadline comparison across the timebase wrap
    @(posedge clock);
    #1 doReset();
    n = 0;
    while (now != 16'hFFEF && n < 70000) begin
      @(posedge clock);
      #1 n++;
    end
    checkOutput("wrap_reach", 32'(now), 32'hFFEF);
    expectServe(1, 16'hFFF8);
    expectServe(0, 16'h0005);
    applyStimulus(4'b0011, 16'h0005, 16'hFFF8, 16'd0, 16'd0);
    waitDrain("wrap_drain", 40);
    n = 0;
    while (now != 16'hFFFF && n < 64) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    checkOutput("now_wrap", 32'(now), 32'd0);

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
